multdiv_unit: RTL and testbench

MULTDIV_UNIT -- requirements
Module: multdiv_unit

---
 rtl/multdiv_unit.sv | 198 +++++++++++++++++++
 tb/tb_multdiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply (radix-2 Booth) and divide
// (non-restoring on magnitudes with a sign fix-up at the end). Each operation
// takes 32 iterations after the start edge, then one DONE cycle strobes
// data_resultRDY. A new start is accepted in any state and restarts the unit.
//
// Optional feature macro: MULTDIV_DIVZERO_FAST_EN
//   defined   -> a divide with a zero divisor jumps straight to DONE on the
//                start edge
//   undefined -> a divide by zero runs the full 32 iterations like any divide
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [5:0] LAST_ITER = 6'd31;

  state_t             r_state;
  logic [5:0]         r_count;

  // Booth datapath: multiplicand sign-extended by one bit, and the product
  // register laid out as {accumulator(WIDTH+1), multiplier(WIDTH), q-1}.
  logic [WIDTH:0]     r_mcand;
  logic [2*WIDTH+1:0] r_prod;

  // Divide datapath: signed partial remainder two bits wider than the
  // divisor, quotient register that starts out holding the dividend magnitude.
  logic [WIDTH+1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_divNeg;
  logic               r_divZero;
  logic               r_divOvf;

  logic [WIDTH-1:0]   r_result;
  logic               r_exception;
  logic               r_rdy;
  logic               r_busy;

  logic [WIDTH:0]     w_boothHi;
  logic [WIDTH:0]     w_boothSum;
  logic [2*WIDTH+1:0] w_boothNext;
  logic [WIDTH:0]     w_prodTop;
  logic               w_mulOvf;

  logic [WIDTH+1:0]   w_remShift;
  logic [WIDTH+1:0]   w_divisorExt;
  logic [WIDTH+1:0]   w_remNext;
  logic [WIDTH-1:0]   w_quoNext;
  logic [WIDTH-1:0]   w_divResult;

  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;

  assign w_magA = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign w_magB = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  assign w_boothHi = r_prod[2*WIDTH+1:WIDTH+1];

  // Booth recoding of the current multiplier bit pair: add, subtract or keep.
  always_comb begin
    w_boothSum = w_boothHi;
    case (r_prod[1:0])
      2'b01:   w_boothSum = w_boothHi + r_mcand;
      2'b10:   w_boothSum = w_boothHi - r_mcand;
      default: w_boothSum = w_boothHi;
    endcase
  end

  assign w_boothNext = {w_boothSum[WIDTH], w_boothSum, r_prod[WIDTH:1]};
  assign w_prodTop   = w_boothNext[2*WIDTH:WIDTH];
  assign w_mulOvf    = !((&w_prodTop) || !(|w_prodTop));

  assign w_remShift   = {r_rem[WIDTH:0], r_quo[WIDTH-1]};
  assign w_divisorExt = {2'b00, r_divisor};
  assign w_remNext    = r_rem[WIDTH+1] ? (w_remShift + w_divisorExt)
                                       : (w_remShift - w_divisorExt);
  assign w_quoNext    = {r_quo[WIDTH-2:0], ~w_remNext[WIDTH+1]};

  // Final divide value with the sign fix-up and the divide-by-zero override.
  always_comb begin
    w_divResult = w_quoNext;
    if (r_divZero) begin
      w_divResult = '0;
    end else if (r_divNeg) begin
      w_divResult = ~w_quoNext + 1'b1;
    end
  end

  // Control FSM plus both datapaths; a start pulse always takes priority.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_mcand     <= '0;
      r_prod      <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_divisor   <= '0;
      r_divNeg    <= 1'b0;
      r_divZero   <= 1'b0;
      r_divOvf    <= 1'b0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      r_count   <= '0;
      r_mcand   <= {data_operandA[WIDTH-1], data_operandA};
      r_prod    <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
      r_rem     <= '0;
      r_quo     <= w_magA;
      r_divisor <= w_magB;
      r_divNeg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_divZero <= (data_operandB == '0);
      r_divOvf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (data_operandB == {WIDTH{1'b1}});
      r_rdy     <= 1'b0;
      if (ctrl_MULT) begin
        r_state <= MUL;
        r_busy  <= 1'b1;
      end else begin
`ifdef MULTDIV_DIVZERO_FAST_EN
        if (data_operandB == '0) begin
          r_state     <= DONE;
          r_result    <= '0;
          r_exception <= 1'b1;
          r_rdy       <= 1'b1;
          r_busy      <= 1'b0;
        end else begin
          r_state <= DIV;
          r_busy  <= 1'b1;
        end
`else
        r_state <= DIV;
        r_busy  <= 1'b1;
`endif
      end
    end else begin
      case (r_state)
        MUL: begin
          r_prod  <= w_boothNext;
          r_count <= r_count + 6'd1;
          if (r_count == LAST_ITER) begin
            r_state     <= DONE;
            r_result    <= w_boothNext[WIDTH:1];
            r_exception <= w_mulOvf;
            r_rdy       <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        DIV: begin
          r_rem   <= w_remNext;
          r_quo   <= w_quoNext;
          r_count <= r_count + 6'd1;
          if (r_count == LAST_ITER) begin
            r_state     <= DONE;
            r_result    <= w_divResult;
            r_exception <= r_divZero || r_divOvf;
            r_rdy       <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb_multdiv_unit: directed and randomized checks of multdiv_unit against an
// arithmetic reference model. Honours MULTDIV_DIVZERO_FAST_EN for the
// expected divide-by-zero latency.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks;
  int failures;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One comparison: counts it and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference multiply: full signed product, low word, overflow if the
  // product does not fit in a signed 32-bit value.
  function automatic void modelMul(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p != longint'($signed(r)));
  endfunction

  // Reference divide: truncating signed division with the two special cases.
  function automatic void modelDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic e);
    longint q;
    if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = q[31:0];
      e = 1'b0;
    end
  endfunction

  // Present a start pulse for exactly one edge (E0), then scramble the
  // operands so later changes would show up if the DUT looked at them.
  task automatic applyStimulus(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait (bounded) for the completion strobe and check latency, busy, values
  // and that the strobe lasts a single cycle while the result holds.
  task automatic waitDone(input int expLat, input logic [31:0] expRes, input logic expExc, input string tag);
    int   k      = 0;
    logic busyOk = 1'b1;
    while (data_resultRDY !== 1'b1 && k < 40) begin
      if (busy !== 1'b1) busyOk = 1'b0;
      @(posedge clock);
      #1;
      k++;
    end
    checkOutput({tag, "_latency"}, k, expLat);
    checkOutput({tag, "_busyDuring"}, {31'd0, busyOk}, 32'd1);
    checkOutput({tag, "_busyDone"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_result"}, data_result, expRes);
    checkOutput({tag, "_exception"}, {31'd0, data_exception}, {31'd0, expExc});
    @(posedge clock);
    #1;
    checkOutput({tag, "_rdyOneCycle"}, {31'd0, data_resultRDY}, 32'd0);
    checkOutput({tag, "_resultHold"}, data_result, expRes);
  endtask

  // Complete operation driven against the reference model.
  task automatic runOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] r;
    logic        e;
    int          lat;
    lat = 32;
    if (m) begin
      modelMul(a, b, r, e);
    end else begin
      modelDiv(a, b, r, e);
`ifdef MULTDIV_DIVZERO_FAST_EN
      if (b == 32'd0) lat = 0;
`endif
    end
    applyStimulus(m, d, a, b);
    waitDone(lat, r, e, tag);
  endtask

  initial begin
    logic        quiet;
    logic [31:0] ra;
    logic [31:0] rb;

    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;

    // Reset state of every output.
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_result", data_result, 32'd0);
    checkOutput("reset_exception", {31'd0, data_exception}, 32'd0);
    checkOutput("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed multiply and divide cases.
    runOp(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, "mul_7x-3");
    runOp(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
    runOp(1'b0, 1'b1, 32'hFFFF_FFEF, 32'd5, "div_-17/5");
    runOp(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min/-1");
    runOp(1'b0, 1'b1, 32'd9, 32'd0, "div_by_zero");
    runOp(1'b1, 1'b1, 32'd6, 32'd3, "both_mult_wins");
    runOp(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, "mul_min_min");

    // Restart: a second multiply at E10 replaces the first, one strobe only.
    applyStimulus(1'b1, 1'b0, 32'd3, 32'd4);
    quiet = 1'b1;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY !== 1'b0) quiet = 1'b0;
    end
    checkOutput("restart_noEarlyRdy", {31'd0, quiet}, 32'd1);
    applyStimulus(1'b1, 1'b0, 32'd5, 32'd6);
    waitDone(32, 32'd30, 1'b0, "restart");

    // Reset pulse at E15 of a divide aborts it without a strobe.
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (14) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("abort_result", data_result, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    checkOutput("abort_noRdy", {31'd0, quiet}, 32'd1);
    runOp(1'b0, 1'b1, 32'd100, 32'd7, "after_reset_div");

    // Randomized operations against the model.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) ra = $signed(ra) >>> $urandom_range(8, 28);
      if ($urandom_range(0, 2) == 0) rb = $signed(rb) >>> $urandom_range(8, 30);
      if (i % 2 == 0) runOp(1'b1, 1'b0, ra, rb, "rand_mul");
      else            runOp(1'b0, 1'b1, ra, rb, "rand_div");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
